// File: rtl/ecc_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ecc_err_monitor
// Description : Registered monitor stage after the 16-bit SEC/DED corrector:
//               forwards beats, counts SEC/DED events, captures the first error
//               and raises a level interrupt. Optional ECC_MON_POISON_EN adds
//               an out_poison flag and zeroes the data of DED beats.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_err_monitor #(
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 8,
    parameter int SEC_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_data,
    input  logic              in_sec,
    input  logic              in_ded,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
`ifdef ECC_MON_POISON_EN
    output logic              out_poison,
`endif
    input  logic              clr,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt,
    output logic              cap_valid,
    output logic              cap_ded,
    output logic [ADDR_W-1:0] cap_addr,
    output logic              irq
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAP_SEC = 2'd1,
        S_CAP_DED = 2'd2
    } state_t;

    logic              out_valid_q;
    logic [15:0]       out_data_q;
    logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;
    logic              irq_q, irq_d;
    state_t            state_q, state_base;
    logic [ADDR_W-1:0] cap_addr_q;
    logic              accept, ded_ev, sec_ev;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign ded_ev   = accept && in_ded;
    assign sec_ev   = accept && in_sec && !in_ded;

    // ---------------- data path ----------------
`ifdef ECC_MON_POISON_EN
    logic out_poison_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= 16'h0000;
            out_poison_q <= 1'b0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= in_ded ? 16'h0000 : in_data;
            out_poison_q <= in_ded;
        end else if (out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end
    assign out_poison = out_poison_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= in_data;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    // ---------------- counters and irq ----------------
    // The clear is applied first so a same-cycle event lands on a zeroed count.
    always_comb begin
        sec_cnt_d = clr ? '0 : sec_cnt_q;
        ded_cnt_d = clr ? '0 : ded_cnt_q;
        if (sec_ev && (sec_cnt_d != {CNT_W{1'b1}}))
            sec_cnt_d = sec_cnt_d + 1'b1;
        if (ded_ev && (ded_cnt_d != {CNT_W{1'b1}}))
            ded_cnt_d = ded_cnt_d + 1'b1;
        irq_d = !clr && (irq_q || (ded_cnt_q != '0) ||
                         (sec_cnt_q >= CNT_W'(SEC_THRESH)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            sec_cnt_q <= sec_cnt_d;
            ded_cnt_q <= ded_cnt_d;
            irq_q     <= irq_d;
        end
    end

    // ---------------- capture FSM ----------------
    assign state_base = clr ? S_IDLE : state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cap_addr_q <= '0;
        end else begin
            if (clr) begin
                state_q    <= S_IDLE;
                cap_addr_q <= '0;
            end
            case (state_base)
                S_IDLE: begin
                    if (ded_ev) begin
                        state_q    <= S_CAP_DED;
                        cap_addr_q <= in_addr;
                    end else if (sec_ev) begin
                        state_q    <= S_CAP_SEC;
                        cap_addr_q <= in_addr;
                    end
                end
                S_CAP_SEC: begin
                    if (ded_ev) begin
                        state_q    <= S_CAP_DED;
                        cap_addr_q <= in_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sec_cnt   = sec_cnt_q;
    assign ded_cnt   = ded_cnt_q;
    assign cap_valid = (state_q != S_IDLE);
    assign cap_ded   = (state_q == S_CAP_DED);
    assign cap_addr  = cap_addr_q;
    assign irq       = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_ecc_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ecc_err_monitor
// Description : Directed self-checking bench for ecc_err_monitor (defaults:
//               ADDR_W=8, CNT_W=8, SEC_THRESH=4); honours ECC_MON_POISON_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_err_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sec;
    logic        in_ded;
    logic [7:0]  in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef ECC_MON_POISON_EN
    logic        out_poison;
`endif
    logic        clr;
    logic [7:0]  sec_cnt;
    logic [7:0]  ded_cnt;
    logic        cap_valid;
    logic        cap_ded;
    logic [7:0]  cap_addr;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ecc_err_monitor #(.ADDR_W(8), .CNT_W(8), .SEC_THRESH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sec    (in_sec),
        .in_ded    (in_ded),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef ECC_MON_POISON_EN
        .out_poison(out_poison),
`endif
        .clr       (clr),
        .sec_cnt   (sec_cnt),
        .ded_cnt   (ded_cnt),
        .cap_valid (cap_valid),
        .cap_ded   (cap_ded),
        .cap_addr  (cap_addr),
        .irq       (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one beat for one clock edge, then returns 1 time unit after it.
    task automatic send(input logic [15:0] d, input logic s, input logic e, input logic [7:0] a);
        in_valid = 1'b1;
        in_data  = d;
        in_sec   = s;
        in_ded   = e;
        in_addr  = a;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sec   = 1'b0;
        in_ded   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sec = 1'b0; in_ded = 1'b0;
        in_addr = '0; out_ready = 1'b1; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_data",  out_data,  0);
        chk("rst_sec_cnt",   sec_cnt,   0);
        chk("rst_ded_cnt",   ded_cnt,   0);
        chk("rst_cap_valid", cap_valid, 0);
        chk("rst_cap_addr",  cap_addr,  0);
        chk("rst_irq",       irq,       0);
        rst_n = 1'b1;
        tick();

        // Clean beat
        send(16'hA5A5, 0, 0, 8'h00);
        chk("clean_out_valid", out_valid, 1);
        chk("clean_out_data",  out_data,  16'hA5A5);
        chk("clean_sec_cnt",   sec_cnt,   0);
        chk("clean_cap_valid", cap_valid, 0);
        tick();
        chk("clean_drain",     out_valid, 0);
        chk("clean_irq",       irq,       0);

        // Four SEC beats to threshold
        send(16'h0001, 1, 0, 8'd3);
        send(16'h0002, 1, 0, 8'd4);
        send(16'h0003, 1, 0, 8'd5);
        chk("sec3_cnt", sec_cnt, 3);
        chk("sec3_irq", irq,     0);
        send(16'h0004, 1, 0, 8'd6);
        chk("sec4_cnt",       sec_cnt,   4);
        chk("sec4_irq_lag",   irq,       0);
        chk("sec4_cap_valid", cap_valid, 1);
        chk("sec4_cap_ded",   cap_ded,   0);
        chk("sec4_cap_addr",  cap_addr,  3);
        tick();
        chk("sec4_irq", irq, 1);

        // SEC then DED upgrade then locked
        do_clr();
        chk("clr_sec_cnt",   sec_cnt,   0);
        chk("clr_cap_valid", cap_valid, 0);
        chk("clr_irq",       irq,       0);
        send(16'h0007, 1, 0, 8'd7);
        chk("up_sec_addr", cap_addr, 7);
        chk("up_sec_ded",  cap_ded,  0);
        send(16'h0009, 0, 1, 8'd9);
        chk("up_ded_addr", cap_addr, 9);
        chk("up_ded_ded",  cap_ded,  1);
        chk("up_ded_cnt1", ded_cnt,  1);
        send(16'h000B, 1, 1, 8'd11);
        chk("lock_addr",    cap_addr, 9);
        chk("lock_ded_cnt", ded_cnt,  2);
        chk("lock_sec_cnt", sec_cnt,  1);
        chk("lock_irq",     irq,      1);

        // Backpressure
        do_clr();
        out_ready = 1'b0;
        send(16'h1111, 0, 0, 8'd20);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_data",  out_data,  16'h1111);
        chk("bp_in_ready",  in_ready,  0);
        in_valid = 1'b1; in_data = 16'h2222; in_sec = 1'b1; in_ded = 1'b0; in_addr = 8'd21;
        tick();
        tick();
        chk("bp_hold_data",  out_data,  16'h1111);
        chk("bp_hold_cnt",   sec_cnt,   0);
        chk("bp_hold_cap",   cap_valid, 0);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rel", in_ready, 1);
        send(16'h2222, 1, 0, 8'd21);
        chk("bp_acc_data", out_data, 16'h2222);
        chk("bp_acc_cnt",  sec_cnt,  1);
        chk("bp_acc_addr", cap_addr, 21);

        // Saturation, then clear together with a DED beat
        do_clr();
        in_valid = 1'b1; in_sec = 1'b1; in_ded = 1'b0; in_addr = 8'd1; in_data = 16'h5555;
        repeat (300) @(posedge clk);
        #1;
        in_valid = 1'b0; in_sec = 1'b0;
        chk("sat_sec_cnt", sec_cnt, 255);
        chk("sat_irq",     irq,     1);
        clr = 1'b1;
        send(16'h0BAD, 0, 1, 8'd2);
        clr = 1'b0;
        chk("clrev_sec_cnt", sec_cnt,   0);
        chk("clrev_ded_cnt", ded_cnt,   1);
        chk("clrev_cap_val", cap_valid, 1);
        chk("clrev_cap_ded", cap_ded,   1);
        chk("clrev_addr",    cap_addr,  2);
        chk("clrev_irq",     irq,       0);
        tick();
        chk("clrev_irq_next", irq, 1);

        // DED data handling
        send(16'h1234, 0, 1, 8'd30);
`ifdef ECC_MON_POISON_EN
        chk("ded_data_poisoned", out_data,   16'h0000);
        chk("ded_poison",        out_poison, 1);
        send(16'h4321, 0, 0, 8'd31);
        chk("clean_poison",      out_poison, 0);
        chk("clean_data_pois",   out_data,   16'h4321);
`else
        chk("ded_data_pass",     out_data,   16'h1234);
`endif

        // Async reset mid-transfer
        out_ready = 1'b0;
        send(16'h7777, 1, 0, 8'd40);
        chk("ar_pending", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_sec_cnt",   sec_cnt,   0);
        chk("ar_ded_cnt",   ded_cnt,   0);
        chk("ar_cap_valid", cap_valid, 0);
        chk("ar_irq",       irq,       0);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_no_replay", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
